// File: rtl/axi3_hp_writer_if.sv
// AXI3 HP write-only bus (AW, W and B channels) between the framebuffer
// writer and the HP port of the interconnect.
interface axi3_hp_writer_if;
  logic        awready;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;

  // Burst writer side
  modport master (
    input  awready, wready, bvalid, bresp,
    output awvalid, awaddr, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready
  );

  // Memory / interconnect side
  modport slave (
    output awready, wready, bvalid, bresp,
    input  awvalid, awaddr, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready
  );
endinterface

// File: rtl/axi3_hp_writer.sv
// Single-outstanding AXI3 INCR burst writer for framebuffer fill.
// One DMA_START launches one burst of BURST_SIZE 32-bit words; the producer's
// word stream is passed straight through to the W channel during the data
// phase, and the B response is turned into a DONE pulse plus a sticky error.
// BURST_SIZE must lie in 1..16 (AWLEN is 4 bits wide).
module axi3_hp_writer #(
  parameter int BURST_SIZE = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [29:0]             DMA_WR_ADDR,
  input  logic                    DMA_START,
  output logic                    DMA_READY,
  input  logic [31:0]             DMA_WR_DATA,
  input  logic                    DMA_WR_DATA_VALID,
  output logic                    DMA_WR_DATA_READY,
  output logic                    DMA_DONE,
  output logic                    DMA_ERROR,
  axi3_hp_writer_if.master        m00_axi
);

  // Counter must be able to hold BURST_SIZE itself, hence the +1.
  localparam int CNT_W = $clog2(BURST_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_SIZE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]       state;
  logic [31:0]      burst_addr;
  logic [CNT_W-1:0] beat_cnt;
  logic             done;
  logic             error;

  logic             in_data;
  logic             beat_hs;
  logic             last_hs;
  logic             b_hs;

  assign in_data = (state == DATA);
  assign beat_hs = in_data & DMA_WR_DATA_VALID & m00_axi.wready;
  assign last_hs = beat_hs & (beat_cnt == LAST_BEAT);
  assign b_hs    = (state == RESP) & m00_axi.bvalid;

  // Producer-facing status
  assign DMA_READY         = (state == IDLE);
  assign DMA_WR_DATA_READY = in_data & m00_axi.wready;
  assign DMA_DONE          = done;
  assign DMA_ERROR         = error;

  // Address channel: address and length held stable for the whole AW phase
  assign m00_axi.awvalid = (state == ADDR);
  assign m00_axi.awaddr  = burst_addr;
  assign m00_axi.awlen   = 4'(BURST_SIZE - 1);
  assign m00_axi.awsize  = 3'b010;
  assign m00_axi.awburst = 2'b01;

  // Data channel: combinational pass-through gated to the data phase
  assign m00_axi.wvalid = in_data & DMA_WR_DATA_VALID;
  assign m00_axi.wdata  = DMA_WR_DATA;
  assign m00_axi.wstrb  = 4'hF;
  assign m00_axi.wlast  = in_data & DMA_WR_DATA_VALID & (beat_cnt == LAST_BEAT);

  // Response channel
  assign m00_axi.bready = (state == RESP);

  // Burst sequencing: capture start address, count beats, wait for B
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      burst_addr <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (DMA_START) begin
            burst_addr <= {DMA_WR_ADDR, 2'b00};
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (m00_axi.awready) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (last_hs) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pulse and sticky error, both registered off the B handshake
  always_ff @(posedge CLK) begin
    if (RESET) begin
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= b_hs;
      if (b_hs && (m00_axi.bresp != 2'b00)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi3_hp_writer.sv
// Bench for axi3_hp_writer: an 8-beat engine exercised with random data and
// random AXI / producer backpressure, plus a 1-beat engine.
module tb_axi3_hp_writer;
  localparam int BS = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RESET = 1'b1;

  // 8-beat engine
  logic [29:0] wr_addr = '0;
  logic        start   = 1'b0;
  logic        ready;
  logic [31:0] wr_data = '0;
  logic        dvalid  = 1'b0;
  logic        dready;
  logic        done;
  logic        error;
  axi3_hp_writer_if bus();

  axi3_hp_writer #(.BURST_SIZE(BS)) dut (
    .CLK(CLK), .RESET(RESET),
    .DMA_WR_ADDR(wr_addr), .DMA_START(start), .DMA_READY(ready),
    .DMA_WR_DATA(wr_data), .DMA_WR_DATA_VALID(dvalid), .DMA_WR_DATA_READY(dready),
    .DMA_DONE(done), .DMA_ERROR(error), .m00_axi(bus)
  );

  // 1-beat engine
  logic [29:0] wr_addr1 = '0;
  logic        start1   = 1'b0;
  logic        ready1;
  logic [31:0] wr_data1 = '0;
  logic        dvalid1  = 1'b0;
  logic        dready1;
  logic        done1;
  logic        error1;
  axi3_hp_writer_if bus1();

  axi3_hp_writer #(.BURST_SIZE(1)) dut_one (
    .CLK(CLK), .RESET(RESET),
    .DMA_WR_ADDR(wr_addr1), .DMA_START(start1), .DMA_READY(ready1),
    .DMA_WR_DATA(wr_data1), .DMA_WR_DATA_VALID(dvalid1), .DMA_WR_DATA_READY(dready1),
    .DMA_DONE(done1), .DMA_ERROR(error1), .m00_axi(bus1)
  );

  int checks = 0;
  int passed = 0;

  // Reference: words the producer will send, in order
  logic [31:0] exp_words [BS];

  // Observations of the last burst
  logic [31:0] obs_data [$];
  logic        obs_last [$];
  logic [31:0] obs_awaddr;
  logic [3:0]  obs_awlen;
  int          aw_hs;
  bit          aw_unstable;
  int          done_pulses;
  int          b_cyc;
  int          done_cyc;
  int          ready_cyc;
  bit          timed_out;

  // Runs one burst on the 8-beat engine acting as producer and AXI slave.
  // Cycle 0 is the DMA_START cycle. abort_at>0 returns after that many beats.
  task automatic drive_burst(input logic [29:0] addr, input bit bp,
                             input logic [1:0] resp, input bit noise,
                             input int abort_at);
    int sent;
    bit hold;
    bit bpend;
    bit prev_wait;
    logic [31:0] prev_addr;
    obs_data.delete();
    obs_last.delete();
    obs_awaddr = 'x; obs_awlen = 'x; aw_hs = 0; aw_unstable = 0;
    done_pulses = 0; b_cyc = -1; done_cyc = -1; ready_cyc = -1; timed_out = 0;
    sent = 0; hold = 0; bpend = 0; prev_wait = 0; prev_addr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 0) begin
        start = 1'b1;
        wr_addr = addr;
      end else begin
        start = noise && !ready && ($urandom_range(0, 2) == 0);
        wr_addr = 30'($urandom());
      end
      bus.awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!hold) begin
        if (sent < BS) begin
          dvalid  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          wr_data = exp_words[sent];
        end else begin
          dvalid  = 1'b0;
          wr_data = $urandom();
        end
      end
      if (!bpend) bus.bvalid = 1'b0;
      else if (!bus.bvalid) bus.bvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bresp = resp;

      @(negedge CLK);
      if (bus.awvalid && prev_wait && (bus.awaddr !== prev_addr)) aw_unstable = 1;
      prev_wait = bus.awvalid && !bus.awready;
      prev_addr = bus.awaddr;
      if (bus.awvalid && bus.awready) begin
        aw_hs++;
        obs_awaddr = bus.awaddr;
        obs_awlen  = bus.awlen;
      end
      if (bus.wvalid && bus.wready) begin
        obs_data.push_back(bus.wdata);
        obs_last.push_back(bus.wlast);
        if (bus.wlast) bpend = 1;
      end
      hold = dvalid && !dready;
      if (dvalid && dready) sent++;
      if (bus.bvalid && bus.bready) begin
        b_cyc = cyc;
        bpend = 0;
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc > 0 && ready && ready_cyc < 0) ready_cyc = cyc;
      @(posedge CLK);
      #1;
      if (abort_at > 0 && obs_data.size() >= abort_at) return;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        start = 1'b0; dvalid = 1'b0; bus.bvalid = 1'b0;
        return;
      end
    end
    timed_out = 1;
    start = 1'b0; dvalid = 1'b0; bus.bvalid = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    start = 1'b0; dvalid = 1'b1; wr_data = '1;
    bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    start1 = 1'b0; dvalid1 = 1'b0;
    bus1.awready = 1'b1; bus1.wready = 1'b1; bus1.bvalid = 1'b0; bus1.bresp = 2'b00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else passed++;
    checks++; if (bus.awvalid !== 1'b0) $display("FAIL reset_awvalid got %b want 0", bus.awvalid); else passed++;
    checks++; if (bus.awaddr !== 32'h0) $display("FAIL reset_awaddr got %h want 0", bus.awaddr); else passed++;
    checks++; if (bus.wvalid !== 1'b0) $display("FAIL reset_wvalid got %b want 0", bus.wvalid); else passed++;
    checks++; if (bus.wlast !== 1'b0) $display("FAIL reset_wlast got %b want 0", bus.wlast); else passed++;
    checks++; if (bus.bready !== 1'b0) $display("FAIL reset_bready got %b want 0", bus.bready); else passed++;
    checks++; if (dready !== 1'b0) $display("FAIL reset_data_ready got %b want 0", dready); else passed++;
    checks++; if ({ready1, error1} !== 2'b10) $display("FAIL reset_one_ready_error got %b want 10", {ready1, error1}); else passed++;
    @(posedge CLK); #1;
    RESET = 1'b0; dvalid = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < BS; i++) exp_words[i] = 32'(i);
    drive_burst(30'h100, 1'b0, 2'b00, 1'b0, 0);
    checks++; if (timed_out !== 1'b0) $display("FAIL basic_timeout got %b want 0", timed_out); else passed++;
    checks++; if (obs_awaddr !== 32'h400) $display("FAIL basic_awaddr got %h want 00000400", obs_awaddr); else passed++;
    checks++; if (obs_awlen !== 4'd7) $display("FAIL basic_awlen got %0d want 7", obs_awlen); else passed++;
    checks++; if ({bus.awsize, bus.awburst, bus.wstrb} !== {3'b010, 2'b01, 4'hF})
      $display("FAIL basic_consts got %h want %h", {bus.awsize, bus.awburst, bus.wstrb}, {3'b010, 2'b01, 4'hF}); else passed++;
    checks++; if (obs_data.size() != BS) $display("FAIL basic_beats got %0d want %0d", obs_data.size(), BS); else passed++;
    for (int i = 0; i < obs_data.size() && i < BS; i++) begin
      checks++; if (obs_data[i] !== exp_words[i]) $display("FAIL basic_data[%0d] got %h want %h", i, obs_data[i], exp_words[i]); else passed++;
      checks++; if (obs_last[i] !== (i == BS - 1)) $display("FAIL basic_wlast[%0d] got %b want %b", i, obs_last[i], (i == BS - 1)); else passed++;
    end
    checks++; if (done_pulses != 1) $display("FAIL basic_done_pulses got %0d want 1", done_pulses); else passed++;
    checks++; if (done_cyc != b_cyc + 1) $display("FAIL basic_done_timing got %0d want %0d", done_cyc, b_cyc + 1); else passed++;
    // Start cycle through the cycle READY returns spans BURST_SIZE+4 cycles inclusive.
    checks++; if (ready_cyc != BS + 3) $display("FAIL basic_ready_cycle got %0d want %0d", ready_cyc, BS + 3); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL basic_error got %b want 0", error); else passed++;
  endtask

  task automatic test_backpressure();
    logic [29:0] a;
    for (int n = 0; n < 3; n++) begin
      a = 30'($urandom()) & ~30'h7;
      for (int i = 0; i < BS; i++) exp_words[i] = $urandom();
      drive_burst(a, 1'b1, 2'b00, 1'b0, 0);
      checks++; if (timed_out !== 1'b0) $display("FAIL bp_timeout[%0d] got %b want 0", n, timed_out); else passed++;
      checks++; if (obs_awaddr !== {a, 2'b00}) $display("FAIL bp_awaddr[%0d] got %h want %h", n, obs_awaddr, {a, 2'b00}); else passed++;
      checks++; if (aw_unstable !== 1'b0) $display("FAIL bp_aw_stable[%0d] got %b want 0", n, aw_unstable); else passed++;
      checks++; if (obs_data.size() != BS) $display("FAIL bp_beats[%0d] got %0d want %0d", n, obs_data.size(), BS); else passed++;
      for (int i = 0; i < obs_data.size() && i < BS; i++) begin
        checks++; if (obs_data[i] !== exp_words[i]) $display("FAIL bp_data[%0d][%0d] got %h want %h", n, i, obs_data[i], exp_words[i]); else passed++;
        checks++; if (obs_last[i] !== (i == BS - 1)) $display("FAIL bp_wlast[%0d][%0d] got %b want %b", n, i, obs_last[i], (i == BS - 1)); else passed++;
      end
      checks++; if (done_pulses != 1) $display("FAIL bp_done_pulses[%0d] got %0d want 1", n, done_pulses); else passed++;
      checks++; if (done_cyc != b_cyc + 1) $display("FAIL bp_done_timing[%0d] got %0d want %0d", n, done_cyc, b_cyc + 1); else passed++;
    end
  endtask

  task automatic test_ignored_start();
    logic [29:0] a;
    logic [29:0] b;
    a = 30'($urandom()) & ~30'h7;
    b = a ^ 30'h1000;
    for (int i = 0; i < BS; i++) exp_words[i] = $urandom();
    drive_burst(a, 1'b1, 2'b00, 1'b1, 0);
    checks++; if (timed_out !== 1'b0) $display("FAIL ign_timeout got %b want 0", timed_out); else passed++;
    checks++; if (aw_hs != 1) $display("FAIL ign_aw_count got %0d want 1", aw_hs); else passed++;
    checks++; if (obs_awaddr !== {a, 2'b00}) $display("FAIL ign_awaddr got %h want %h", obs_awaddr, {a, 2'b00}); else passed++;
    checks++; if (obs_data.size() != BS) $display("FAIL ign_beats got %0d want %0d", obs_data.size(), BS); else passed++;
    checks++; if (done_pulses != 1) $display("FAIL ign_done_pulses got %0d want 1", done_pulses); else passed++;
    drive_burst(b, 1'b0, 2'b00, 1'b0, 0);
    checks++; if (obs_awaddr !== {b, 2'b00}) $display("FAIL ign_next_awaddr got %h want %h", obs_awaddr, {b, 2'b00}); else passed++;
    checks++; if (done_pulses != 1) $display("FAIL ign_next_done got %0d want 1", done_pulses); else passed++;
  endtask

  task automatic test_error();
    for (int i = 0; i < BS; i++) exp_words[i] = $urandom();
    drive_burst(30'h200, 1'b1, 2'b10, 1'b0, 0);
    checks++; if (error !== 1'b1) $display("FAIL err_set got %b want 1", error); else passed++;
    checks++; if (done_pulses != 1) $display("FAIL err_done got %0d want 1", done_pulses); else passed++;
    drive_burst(30'h208, 1'b0, 2'b00, 1'b0, 0);
    checks++; if (error !== 1'b1) $display("FAIL err_sticky got %b want 1", error); else passed++;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (error !== 1'b0) $display("FAIL err_cleared got %b want 0", error); else passed++;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < BS; i++) exp_words[i] = $urandom();
    drive_burst(30'h300, 1'b0, 2'b00, 1'b0, 3);
    checks++; if (obs_data.size() != 3) $display("FAIL mid_beats_before got %0d want 3", obs_data.size()); else passed++;
    RESET = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (bus.wvalid !== 1'b0) $display("FAIL mid_wvalid got %b want 0", bus.wvalid); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL mid_ready got %b want 1", ready); else passed++;
    @(posedge CLK); #1;
    RESET = 1'b0; dvalid = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < BS; i++) exp_words[i] = $urandom();
    drive_burst(30'h308, 1'b0, 2'b00, 1'b0, 0);
    checks++; if (obs_data.size() != BS) $display("FAIL mid_new_beats got %0d want %0d", obs_data.size(), BS); else passed++;
    for (int i = 0; i < obs_data.size() && i < BS; i++) begin
      checks++; if (obs_data[i] !== exp_words[i]) $display("FAIL mid_new_data[%0d] got %h want %h", i, obs_data[i], exp_words[i]); else passed++;
      checks++; if (obs_last[i] !== (i == BS - 1)) $display("FAIL mid_new_wlast[%0d] got %b want %b", i, obs_last[i], (i == BS - 1)); else passed++;
    end
    checks++; if (done_pulses != 1) $display("FAIL mid_new_done got %0d want 1", done_pulses); else passed++;
  endtask

  task automatic test_burst1();
    logic [29:0] a;
    logic [31:0] w;
    logic [31:0] got_addr;
    logic [31:0] got_data;
    logic [3:0]  got_len;
    logic        got_last;
    int beats, b_at, d_at, r_at;
    bit bpend, consumed;
    a = 30'($urandom()); w = $urandom();
    got_addr = 'x; got_data = 'x; got_len = 'x; got_last = 'x;
    beats = 0; b_at = -1; d_at = -1; r_at = -1; bpend = 0; consumed = 0;
    wr_addr1 = a; start1 = 1'b1; wr_data1 = w; dvalid1 = 1'b1;
    bus1.awready = 1'b1; bus1.wready = 1'b1; bus1.bvalid = 1'b0; bus1.bresp = 2'b00;
    for (int cyc = 0; cyc < 40 && d_at < 0; cyc++) begin
      @(negedge CLK);
      if (bus1.awvalid && bus1.awready) begin got_addr = bus1.awaddr; got_len = bus1.awlen; end
      if (bus1.wvalid && bus1.wready) begin beats++; got_data = bus1.wdata; got_last = bus1.wlast; bpend = 1; end
      if (dvalid1 && dready1) consumed = 1;
      if (bus1.bvalid && bus1.bready) begin b_at = cyc; bpend = 0; end
      if (done1) begin d_at = cyc; r_at = ready1 ? cyc : -1; end
      @(posedge CLK); #1;
      start1 = 1'b0;
      dvalid1 = !consumed;
      bus1.bvalid = bpend;
    end
    dvalid1 = 1'b0; bus1.bvalid = 1'b0;
    checks++; if (got_len !== 4'd0) $display("FAIL one_awlen got %0d want 0", got_len); else passed++;
    checks++; if (got_addr !== {a, 2'b00}) $display("FAIL one_awaddr got %h want %h", got_addr, {a, 2'b00}); else passed++;
    checks++; if (beats != 1) $display("FAIL one_beats got %0d want 1", beats); else passed++;
    checks++; if (got_data !== w) $display("FAIL one_data got %h want %h", got_data, w); else passed++;
    checks++; if (got_last !== 1'b1) $display("FAIL one_wlast got %b want 1", got_last); else passed++;
    checks++; if (d_at != b_at + 1 || d_at < 0) $display("FAIL one_done_timing got %0d want %0d", d_at, b_at + 1); else passed++;
    checks++; if (r_at != d_at) $display("FAIL one_ready got %0d want %0d", r_at, d_at); else passed++;
    checks++; if ({bus1.awsize, bus1.awburst, bus1.wstrb} !== {3'b010, 2'b01, 4'hF})
      $display("FAIL one_consts got %h want %h", {bus1.awsize, bus1.awburst, bus1.wstrb}, {3'b010, 2'b01, 4'hF}); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_error();
    test_reset_mid();
    test_burst1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi3_hp_writer.md
# axi3_hp_writer

Single-clock AXI3 burst-write DMA engine that fills the framebuffer later scanned out by the LCD controller's AXI3 read path. A producer in the `CLK` domain, such as a pixel renderer or blitter, issues one start request per burst. It then streams exactly `BURST_SIZE` 32-bit words. The block drives the AXI3 HP write address, data and response channels, and reports completion and error status back to the producer.

## Interface
Parameters:
- `BURST_SIZE`, default 8: words per burst. Legal range 1..16 (AXI3 `AWLEN` limit). `AWLEN = BURST_SIZE-1`.

Ports:
- Clock and reset are fixed: one clock, `CLK`; `RESET` is synchronous and active-high.
- `CLK`  in  1  DMA clock; all logic in this domain.
- `RESET`  in  1  synchronous reset, active-high.
- `DMA_WR_ADDR`  in  30  word address of the burst start; byte address = `{DMA_WR_ADDR, 2'b00}`.
- `DMA_START`  in  1  one-cycle request; honoured only when `DMA_READY`=1, ignored otherwise.
- `DMA_READY`  out  1  engine idle and able to accept `DMA_START`.
- `DMA_WR_DATA`  in  32  write word.
- `DMA_WR_DATA_VALID`  in  1  producer has a word on `DMA_WR_DATA`.
- `DMA_WR_DATA_READY`  out  1  word is consumed this cycle when both this and `DMA_WR_DATA_VALID` are 1.
- `DMA_DONE`  out  1  one-cycle pulse when the B response for the burst is accepted.
- `DMA_ERROR`  out  1  sticky flag: a non-OKAY `BRESP` was seen. Cleared only by `RESET`.
- `m00_axi_awready`  in  1; `m00_axi_awvalid`  out  1; `m00_axi_awaddr`  out  32; `m00_axi_awlen`  out  4; `m00_axi_awsize`  out  3 (constant `3'b010`); `m00_axi_awburst`  out  2 (constant `2'b01`, INCR).
- `m00_axi_wready`  in  1; `m00_axi_wvalid`  out  1; `m00_axi_wdata`  out  32; `m00_axi_wstrb`  out  4 (constant `4'hF`); `m00_axi_wlast`  out  1.
- `m00_axi_bvalid`  in  1; `m00_axi_bresp`  in  2; `m00_axi_bready`  out  1.

## Operation
- The state machine has four states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - `DMA_READY`=1.
  - On `DMA_START`, register `{DMA_WR_ADDR,2'b00}` into `awaddr` and go to ADDR.
- **ADDR**
  - `awvalid`=1; `awaddr` and `awlen` are held stable.
  - On `awready`, go to DATA and clear the beat counter.
- **DATA**
  - Data path is a combinational pass-through: `wvalid = DMA_WR_DATA_VALID`, `wdata = DMA_WR_DATA`, `DMA_WR_DATA_READY = wready`.
  - Each beat with `wvalid & wready` increments the beat counter. The counter is `$clog2(BURST_SIZE+1)` bits wide.
  - `wlast` = (beat counter == `BURST_SIZE-1`) & `wvalid`.
  - The `wlast` handshake moves the state to RESP.
- **RESP**
  - `bready`=1.
  - On `bvalid`: pulse `DMA_DONE`, set `DMA_ERROR` if `bresp` != `2'b00`, and return to IDLE.
- Outside DATA, `wvalid`=0 and `DMA_WR_DATA_READY`=0. The producer may hold `DMA_WR_DATA_VALID` high early; no word is consumed until DATA.
- The block accepts no new `DMA_START` until the B response is accepted, so at most one burst is outstanding.
- The producer guarantees the burst does not cross a 4 KB boundary. For power-of-two `BURST_SIZE`, this means `DMA_WR_ADDR` is aligned to `BURST_SIZE`. The block performs no splitting.

## Timing
- **Reset values:** state=IDLE, `DMA_READY`=1, `DMA_DONE`=0, `DMA_ERROR`=0, `awvalid`=0, `awaddr`=0, `wvalid`=0, `wlast`=0, `bready`=0, `DMA_WR_DATA_READY`=0.
- **`RESET` mid-burst:** the block returns to IDLE on the next edge and abandons the AXI transaction. System-level reset of the interconnect is required alongside it.
- **Address phase:** `DMA_START` in cycle N gives `awvalid`=1 in cycle N+1.
- **Data phase:**
  - The first `wvalid` is possible in the cycle after the AW handshake.
  - Zero-wait throughput is 1 word/cycle.
- **Completion:** `DMA_DONE` is registered, asserted in the cycle after the `bvalid & bready` handshake. `DMA_READY` rises in that same cycle.
- **Best-case turnaround:** `DMA_START` to the next-accepted `DMA_START` is `BURST_SIZE`+4 cycles.
- **`BURST_SIZE`=1:** `wlast`=1 on the first and only beat.
- **Stalls:** a stall in either `wready` or `DMA_WR_DATA_VALID` holds the beat counter. The AXI rule that `wvalid` cannot drop once asserted is the producer's responsibility: `DMA_WR_DATA_VALID` must not drop before its handshake.

## Test plan
- **Basic burst:** after reset, `DMA_WR_ADDR`=`30'h100`, `BURST_SIZE`=8, slave always ready.
  - `awaddr`=`32'h400`, `awlen`=7.
  - Eight beats with data `0..7`; `wlast` only on beat 7.
  - `DMA_DONE` pulses once; total 12 cycles to `DMA_READY`.
- **Backpressure:** random `awready`, `wready` and `DMA_WR_DATA_VALID` gaps.
  - Data order preserved; exactly 8 beats.
  - `awaddr` stable while `awvalid` is high without `awready`.
- **Ignored start:** `DMA_START` pulsed during DATA and RESP has no effect. A pulse with `DMA_READY`=1 after `DMA_DONE` starts the next burst at the new address.
- **Error response:** `bresp`=`2'b10` on burst 1.
  - `DMA_ERROR`=1 and remains 1 through an OKAY burst 2.
  - Cleared only by `RESET`.
- **Reset mid-DATA:** assert `RESET` after 3 beats.
  - Next cycle: `wvalid`=0, `DMA_READY`=1.
  - A new burst completes with `wlast` on beat `BURST_SIZE-1`.
- **`BURST_SIZE`=1:** `awlen`=0, single beat with `wlast`=1, `DMA_DONE` after the B handshake.
